// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: mul opcode and arbiter FSM state types shared by the mul_arbiter slice
package mul_arbiter_pkg;
    typedef enum logic [1:0] {MUL, MULH, MULHU, MULHSU} mul_op_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mul_arb_state_t;
endpackage

// File: rtl/mul_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after prio, wrapping
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] prio,
    output logic [N-1:0]  gnt
);
    logic [N-1:0] rot, pick;
    // rotate so prio sits at bit 0, keep the lowest set bit, rotate back
    always_comb begin
        rot  = N'({req, req} >> prio);
        pick = rot & (-rot);
        gnt  = N'({pick, pick} >> (N - int'(prio)));
    end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multi-cycle mul unit among NREQ requesters
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][63:0] req_in1,
    input  logic [NREQ-1:0][63:0] req_in2,
    input  logic [NREQ-1:0]       req_word,
    input  mul_op_t [NREQ-1:0]    req_op,
    input  logic [NREQ-1:0]       flush,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [63:0]           resp_data,
    output logic [63:0]           mul_in1,
    output logic [63:0]           mul_in2,
    output logic                  mul_word,
    output mul_op_t               mul_op,
    output logic                  mul_en,
    input  logic [63:0]           mul_out,
    input  logic                  mul_out_valid,
    output logic                  mul_out_ready
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    mul_arb_state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, prio_q, prio_d, win;
    logic killed_q, killed_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic [NREQ-1:0] cand, gnt;
    logic live;
    assign live = !reset;
    // reset gating keeps every output low while reset is held
    assign cand = (state_q == IDLE && live) ? req_valid & ~flush : '0;
    rr_arbiter #(.N(NREQ), .PW(IW)) u_rr (
        .req  (cand),
        .prio (prio_q),
        .gnt  (gnt)
    );
    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) win = IW'(i);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            prio_q      <= '0;
            killed_q    <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            killed_q    <= killed_d;
            resp_data_q <= resp_data_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        killed_d    = killed_q;
        resp_data_d = resp_data_q;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d  = WAIT;
                owner_d  = win;
                prio_d   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                killed_d = 1'b0;
            end
            // the result is always drained so mul never stalls; a kill only drops it
            WAIT: begin
                killed_d = killed_q | flush[owner_q];
                if (mul_out_valid) begin
                    state_d     = killed_d ? IDLE : RESP;
                    resp_data_d = mul_out;
                end
            end
            RESP: state_d = (resp_ready[owner_q] || flush[owner_q]) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        req_ready     = gnt;
        mul_en        = |gnt;
        mul_in1       = mul_en ? req_in1[win] : '0;
        mul_in2       = mul_en ? req_in2[win] : '0;
        mul_word      = mul_en && req_word[win];
        mul_op        = mul_en ? req_op[win] : MUL;
        mul_out_ready = live && state_q == WAIT;
        resp_valid    = (live && state_q == RESP) ? NREQ'(1) << owner_q : '0;
        resp_data     = resp_data_q;
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed vectors plus randomized traffic checked against a cycle-level reference model
module tb_mul_arbiter;
    import mul_arbiter_pkg::*;
    localparam int NREQ = 2;

    logic clock = 1'b0, reset = 1'b1;
    logic [NREQ-1:0] req_valid, req_ready, req_word, flush, resp_valid, resp_ready;
    logic [NREQ-1:0][63:0] req_in1, req_in2;
    mul_op_t [NREQ-1:0] req_op;
    logic [63:0] resp_data, mul_in1, mul_in2, mul_out;
    logic mul_word, mul_en, mul_out_valid, mul_out_ready;
    mul_op_t mul_op;

    always #5 clock = ~clock;

    mul_arbiter #(.NREQ(NREQ)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_word(req_word), .req_op(req_op),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_word(mul_word), .mul_op(mul_op),
        .mul_en(mul_en), .mul_out(mul_out), .mul_out_valid(mul_out_valid),
        .mul_out_ready(mul_out_ready)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic w, input mul_op_t op);
        logic [127:0] ea, eb, p;
        logic a_s, b_s;
        a_s = (op != MULHU);
        b_s = (op == MUL || op == MULH);
        if (w) begin
            ea = a_s ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
            eb = b_s ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
            p = ea * eb;
            return (op == MUL) ? {{32{p[31]}}, p[31:0]} : {{32{p[63]}}, p[63:32]};
        end
        ea = a_s ? {{64{a[63]}}, a} : {64'b0, a};
        eb = b_s ? {{64{b[63]}}, b} : {64'b0, b};
        p = ea * eb;
        return (op == MUL) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
        return '0;
    endfunction

    // environment model of the mul unit: latch on en, result valid two cycles later
    logic m_busy = 1'b0, m_valid = 1'b0;
    logic [63:0] m_res = '0;
    always @(posedge clock) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (mul_en) begin
            m_busy <= 1'b1;
            m_res  <= ref_mul(mul_in1, mul_in2, mul_word, mul_op);
        end else if (m_busy) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid && mul_out_ready) begin
            m_valid <= 1'b0;
        end
    end
    assign mul_out_valid = m_valid;
    assign mul_out = m_res;

    // reference model: an op owns the unit from accept until response taken or killed
    bit model_en = 0, m_pend = 0, m_kill = 0;
    int m_age = 0, m_owner = 0, m_prio = 0;
    logic [63:0] m_data = '0;
    always @(negedge clock) begin
        if (model_en) begin : model
            logic [NREQ-1:0] e_rdy, e_rv;
            int w;
            e_rdy = m_pend ? '0 : rr_pick(req_valid & ~flush, m_prio);
            e_rv  = (m_pend && m_age >= 3) ? NREQ'(1) << m_owner : '0;
            chk("rnd_ready", req_ready, e_rdy);
            chk("rnd_en", mul_en, |e_rdy);
            chk("rnd_mor", mul_out_ready, m_pend && m_age < 3);
            chk("rnd_rv", resp_valid, e_rv);
            if (e_rv != 0) chk("rnd_data", resp_data, m_data);
            if (e_rdy != 0) begin
                w = 0;
                for (int i = 0; i < NREQ; i++) if (e_rdy[i]) w = i;
                chk("rnd_in1", mul_in1, req_in1[w]);
                chk("rnd_in2", mul_in2, req_in2[w]);
                chk("rnd_word", mul_word, req_word[w]);
                chk("rnd_op", mul_op, req_op[w]);
                m_pend = 1; m_age = 1; m_owner = w; m_prio = (w + 1) % NREQ; m_kill = 0;
                m_data = ref_mul(req_in1[w], req_in2[w], req_word[w], req_op[w]);
            end else if (m_pend && m_age < 3) begin
                if (flush[m_owner]) m_kill = 1;
                if (m_age == 2 && m_kill) m_pend = 0;
                m_age++;
            end else if (m_pend && (resp_ready[m_owner] || flush[m_owner])) begin
                m_pend = 0;
            end
        end
    end

    typedef struct {
        int r;
        logic [63:0] a, b;
        logic w;
        mul_op_t op;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        req_valid = '0; flush = '0; resp_ready = '0;
    endtask

    task automatic put(input int r, input logic [63:0] a, input logic [63:0] b,
                       input logic w, input mul_op_t op);
        req_valid[r] = 1'b1; req_in1[r] = a; req_in2[r] = b; req_word[r] = w; req_op[r] = op;
    endtask

    task automatic drain(input string name, input logic [NREQ-1:0] erv, input logic [63:0] ed);
        int n = 0;
        while (resp_valid === '0 && n < 8) begin tick(); #1; n++; end
        chk({name, "_rv"}, resp_valid, erv);
        chk({name, "_data"}, resp_data, ed);
        resp_ready = '1; tick(); resp_ready = '0;
    endtask

    task automatic run_vec(input vec_t v);
        clr(); put(v.r, v.a, v.b, v.w, v.op); #1;
        chk("vec_ready", req_ready, 64'(1) << v.r);
        chk("vec_en", mul_en, 1);
        tick(); req_valid = '0; #1;
        chk("vec_t1_en", mul_en, 0);
        chk("vec_t1_rv", resp_valid, 0);
        tick(); #1;
        chk("vec_t2_mor", mul_out_ready, 1);
        chk("vec_t2_rv", resp_valid, 0);
        tick(); #1;
        chk("vec_t3_rv", resp_valid, 64'(1) << v.r);
        chk("vec_data", resp_data, v.exp);
        resp_ready = '1; tick(); resp_ready = '0; #1;
        chk("vec_t4_rv", resp_valid, 0);
    endtask

    initial begin
        int g_idx[$], g_cyc[$];
        bit two, seen;
        vecs[0] = '{0, 64'd3, 64'd5, 1'b0, MUL, 64'd15};
        vecs[1] = '{1, '1, '1, 1'b0, MULH, 64'd0};
        vecs[2] = '{1, '1, '1, 1'b0, MULHU, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3] = '{0, '1, '1, 1'b0, MULHSU, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{1, 64'h7FFF_FFFF, 64'd2, 1'b1, MUL, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5] = '{0, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, MULHU, 64'd1};
        vecs[6] = '{1, 64'hFFFF_FFFF_8000_0000, 64'd2, 1'b1, MULH, 64'hFFFF_FFFF_FFFF_FFFF};

        // reset state with both requesters already asserting
        clr(); req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_in1[i] = 64'd2; req_in2[i] = 64'd3; req_word[i] = 1'b0; req_op[i] = MUL;
        end
        tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_en", mul_en, 0);
        chk("rst_rv", resp_valid, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_mor", mul_out_ready, 0);
        reset = 1'b0; #1;
        chk("rst_live_ready", req_ready, 2'b01);

        // round robin under continuous demand
        resp_ready = '1; two = 0;
        for (int c = 0; c < 40 && g_idx.size() < 4; c++) begin
            if ($countones(req_ready) > 1) two = 1;
            if (mul_en) begin g_idx.push_back(req_ready[1] ? 1 : 0); g_cyc.push_back(c); end
            tick(); #1;
        end
        chk("rr_count", g_idx.size(), 4);
        chk("rr_twohot", two, 0);
        for (int i = 0; i < g_idx.size(); i++) chk("rr_order", g_idx[i], i % 2);
        for (int i = 1; i < g_cyc.size(); i++) chk("rr_gap", g_cyc[i] - g_cyc[i-1], 4);
        req_valid = '0;
        repeat (4) tick();
        clr();

        foreach (vecs[i]) run_vec(vecs[i]);

        // flush of the owner while mul is busy
        clr(); put(0, 7, 9, 0, MUL); #1;
        chk("fl_accept", req_ready, 2'b01);
        tick(); req_valid = '0; flush = 2'b01; put(1, 4, 4, 0, MUL); #1;
        chk("fl_t1_ready", req_ready, 0);
        tick(); flush = '0; #1;
        chk("fl_t2_mor", mul_out_ready, 1);
        chk("fl_t2_rv", resp_valid, 0);
        tick(); #1;
        chk("fl_t3_rv", resp_valid, 0);
        chk("fl_t3_ready", req_ready, 2'b10);
        chk("fl_t3_en", mul_en, 1);
        tick(); req_valid = '0; #1;
        drain("fl_next", 2'b10, 64'd16);

        // non-owner flush in WAIT is ignored; owner flush in RESP drops the response
        clr(); put(0, 6, 7, 0, MUL); #1;
        chk("nf_accept", req_ready, 2'b01);
        tick(); req_valid = '0; flush = 2'b10; #1;
        tick(); flush = '0; #1;
        tick(); #1;
        chk("nf_rv", resp_valid, 2'b01);
        chk("nf_data", resp_data, 64'd42);
        flush = 2'b01; tick(); flush = '0; #1;
        chk("rf_rv", resp_valid, 0);
        put(1, 5, 5, 0, MUL); #1;
        chk("rf_ready", req_ready, 2'b10);
        tick(); req_valid = '0; #1;
        drain("rf_next", 2'b10, 64'd25);

        // flush coinciding with mul_out_valid drops the result
        clr(); put(1, 3, 3, 0, MUL); #1;
        chk("fv_accept", req_ready, 2'b10);
        tick(); req_valid = '0; #1;
        tick(); flush = 2'b10; #1;
        chk("fv_mov", mul_out_valid, 1);
        tick(); flush = '0; put(0, 1, 1, 0, MUL); #1;
        chk("fv_rv", resp_valid, 0);
        chk("fv_ready", req_ready, 2'b01);
        tick(); req_valid = '0; #1;
        drain("fv_next", 2'b01, 64'd1);

        // response backpressure
        clr(); put(1, 11, 3, 0, MUL); #1;
        chk("bp_accept", req_ready, 2'b10);
        tick(); req_valid = '0; #1;
        tick(); #1;
        tick(); put(0, 2, 2, 0, MUL); #1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_rv", resp_valid, 2'b10);
            chk("bp_data", resp_data, 64'd33);
            chk("bp_en", mul_en, 0);
            chk("bp_ready", req_ready, 0);
            tick(); #1;
        end
        resp_ready = 2'b10; tick(); resp_ready = '0; #1;
        chk("bp_after_ready", req_ready, 2'b01);
        chk("bp_after_en", mul_en, 1);
        tick(); req_valid = '0; #1;
        drain("bp_r0", 2'b01, 64'd4);

        // reset in the middle of an op
        clr(); put(0, 9, 9, 0, MUL); #1;
        chk("rm_accept", req_ready, 2'b01);
        tick(); req_valid = '0; reset = 1'b1; #1;
        tick(); #1;
        chk("rm_ready", req_ready, 0);
        chk("rm_rv", resp_valid, 0);
        chk("rm_en", mul_en, 0);
        chk("rm_mor", mul_out_ready, 0);
        chk("rm_data", resp_data, 0);
        reset = 1'b0; seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid !== '0) seen = 1;
            tick(); #1;
        end
        chk("rm_noresp", seen, 0);
        put(1, 8, 8, 0, MUL); #1;
        chk("rm_new_accept", req_ready, 2'b10);
        tick(); req_valid = '0; #1;
        drain("rm_new", 2'b10, 64'd64);

        // randomized traffic against the reference model
        reset = 1'b1; clr(); tick(); tick(); reset = 1'b0;
        m_pend = 0; m_prio = 0; m_kill = 0; model_en = 1;
        repeat (2000) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]  = ($urandom_range(0, 3) != 0);
                flush[i]      = ($urandom_range(0, 9) == 0);
                resp_ready[i] = 1'($urandom_range(0, 1));
                req_in1[i]    = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
                req_in2[i]    = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
                req_word[i]   = 1'($urandom_range(0, 1));
                req_op[i]     = mul_op_t'($urandom_range(0, 3));
            end
        end
        tick();
        model_en = 0;
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
